// File: rtl/fc_weight_pingpong_buf.sv
// Two-bank ping-pong weight buffer: one bank fills while the other is read.
// Optional macro FC_WBUF_LANE_MASK_EN enables per-lane write masking via wlane_mask_i.
module fc_weight_pingpong_buf #(
  parameter  int LANES = 128,
  parameter  int DW    = 8,
  parameter  int DEPTH = 128,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wren_i,
  input  logic [AW-1:0]       wrptr_i,
  input  logic [LANES-1:0]    wlane_mask_i,
  input  logic [LANES*DW-1:0] weight_i,
  input  logic                wr_commit_i,
  input  logic                rden_i,
  input  logic [AW-1:0]       rdptr_i,
  input  logic                zero_i,
  input  logic                rd_release_i,
  output logic [LANES*DW-1:0] weight_o,
  output logic                valid_o,
  output logic                wr_ready_o,
  output logic                rd_ready_o,
  output logic                wr_bank_o,
  output logic                rd_bank_o,
  output logic                wr_ovf_o,
  output logic                rd_udf_o
);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } bank_state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  bank_state_e         r_state [2];
  bank_state_e         w_state_nxt [2];
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [LANES*DW-1:0] r_mem [2][DEPTH];
  logic [LANES*DW-1:0] r_weight;
  logic                r_valid;
  logic                r_wr_ovf;
  logic                r_rd_udf;

  logic [LANES-1:0]    w_lane_en;
  logic                w_wr_ready;
  logic                w_rd_ready;
  logic                w_wr_acc;
  logic                w_commit;
  logic                w_rd_acc;
  logic                w_release;
  logic                w_wr_in_range;
  logic                w_rd_in_range;

`ifdef FC_WBUF_LANE_MASK_EN
  assign w_lane_en = wlane_mask_i;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^wlane_mask_i;
  assign w_lane_en     = {LANES{1'b1}};
`endif

  assign w_wr_ready    = (r_state[r_wr_bank] == ST_FREE) || (r_state[r_wr_bank] == ST_FILL);
  assign w_rd_ready    = (r_state[r_rd_bank] == ST_READY) || (r_state[r_rd_bank] == ST_READ);
  assign w_wr_in_range = ({1'b0, wrptr_i} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, rdptr_i} < DEPTH_W);
  assign w_wr_acc      = wren_i & w_wr_ready & w_wr_in_range;
  assign w_commit      = wr_commit_i & w_wr_ready;
  assign w_rd_acc      = rden_i & w_rd_ready & ~zero_i;
  assign w_release     = rd_release_i & w_rd_ready;

  // Per-bank lifecycle; write-side events only reach FREE/FILL banks, read-side only READY/READ
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      case (r_state[b])
        ST_FREE: begin
          if (w_commit && (r_wr_bank == 1'(b))) begin
            w_state_nxt[b] = ST_READY;
          end else if (w_wr_acc && (r_wr_bank == 1'(b))) begin
            w_state_nxt[b] = ST_FILL;
          end else begin
            w_state_nxt[b] = ST_FREE;
          end
        end
        ST_FILL: begin
          if (w_commit && (r_wr_bank == 1'(b))) begin
            w_state_nxt[b] = ST_READY;
          end else begin
            w_state_nxt[b] = ST_FILL;
          end
        end
        ST_READY: begin
          if (w_release && (r_rd_bank == 1'(b))) begin
            w_state_nxt[b] = ST_FREE;
          end else if (w_rd_acc && (r_rd_bank == 1'(b))) begin
            w_state_nxt[b] = ST_READ;
          end else begin
            w_state_nxt[b] = ST_READY;
          end
        end
        ST_READ: begin
          if (w_release && (r_rd_bank == 1'(b))) begin
            w_state_nxt[b] = ST_FREE;
          end else begin
            w_state_nxt[b] = ST_READ;
          end
        end
        default: w_state_nxt[b] = ST_FREE;
      endcase
    end
  end

  // Bank states and bank pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= ST_FREE;
      r_state[1] <= ST_FREE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      if (w_commit) r_wr_bank <= ~r_wr_bank;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Sticky protocol error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ovf <= 1'b0;
      r_rd_udf <= 1'b0;
    end else begin
      if ((wren_i | wr_commit_i) & ~w_wr_ready) r_wr_ovf <= 1'b1;
      if (rden_i & ~zero_i & ~w_rd_ready) r_rd_udf <= 1'b1;
    end
  end

  // Registered read port; the row is fetched from the read bank before any same-edge release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight <= '0;
      r_valid  <= 1'b0;
    end else if (rden_i) begin
      if (zero_i) begin
        r_weight <= '0;
        r_valid  <= 1'b1;
      end else if (!w_rd_ready) begin
        r_weight <= '0;
        r_valid  <= 1'b0;
      end else if (!w_rd_in_range) begin
        r_weight <= '0;
        r_valid  <= 1'b1;
      end else begin
        r_weight <= r_mem[r_rd_bank][rdptr_i];
        r_valid  <= 1'b1;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Weight storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_lane_en[k]) r_mem[r_wr_bank][wrptr_i][k*DW +: DW] <= weight_i[k*DW +: DW];
      end
    end
  end

  assign weight_o   = r_weight;
  assign valid_o    = r_valid;
  assign wr_ready_o = w_wr_ready;
  assign rd_ready_o = w_rd_ready;
  assign wr_bank_o  = r_wr_bank;
  assign rd_bank_o  = r_rd_bank;
  assign wr_ovf_o   = r_wr_ovf;
  assign rd_udf_o   = r_rd_udf;

endmodule

// File: tb/tb_fc_weight_pingpong_buf.sv
// Self-checking bench for fc_weight_pingpong_buf: directed scenarios plus random traffic
// checked every cycle against a bank-lifecycle reference model.
module tb_fc_weight_pingpong_buf;
  localparam int LANES = 128;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int W     = LANES * DW;
  localparam int S_FREE = 0, S_FILL = 1, S_READY = 2, S_READ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, wren, commit, rden, zero, rel;
  logic [AW-1:0] wrptr, rdptr;
  logic [LANES-1:0] wmask;
  logic [W-1:0] wdata;
  logic [W-1:0] weight_o;
  logic valid_o, wr_ready_o, rd_ready_o, wr_bank_o, rd_bank_o, wr_ovf_o, rd_udf_o;

  fc_weight_pingpong_buf #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wren_i(wren), .wrptr_i(wrptr), .wlane_mask_i(wmask), .weight_i(wdata),
    .wr_commit_i(commit), .rden_i(rden), .rdptr_i(rdptr), .zero_i(zero),
    .rd_release_i(rel), .weight_o(weight_o), .valid_o(valid_o),
    .wr_ready_o(wr_ready_o), .rd_ready_o(rd_ready_o), .wr_bank_o(wr_bank_o),
    .rd_bank_o(rd_bank_o), .wr_ovf_o(wr_ovf_o), .rd_udf_o(rd_udf_o)
  );

  // Reference model state
  int          m_state [2];
  int          m_wb, m_rb;
  bit          m_ovf, m_udf, m_valid;
  logic [W-1:0] m_w, m_wk;
  byte unsigned m_mem [2][DEPTH][LANES];
  bit           m_known [2][DEPTH][LANES];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      int k;
      k = 0;
      for (int i = LANES - 1; i >= 0; i--) if (obs[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
      n_errors++;
      $display("FAIL %s: got %0h want %0h (lane %0d)", tag, obs[k*DW +: DW], exp[k*DW +: DW], k);
    end
  endtask

  function automatic logic [W-1:0] row_of(input logic [7:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] model_row(input int b, input int r);
    logic [W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = m_mem[b][r][k];
    return v;
  endfunction

  function automatic bit lane_on(input int k);
`ifdef FC_WBUF_LANE_MASK_EN
    return wmask[k];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_state[0] = S_FREE;
    m_state[1] = S_FREE;
    m_wb = 0; m_rb = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
    m_w = '0; m_wk = '1;
  endtask

  // Predict the effect of the current inputs at the coming clock edge
  task automatic model_step();
    bit wr_rdy, rd_rdy;
    wr_rdy = (m_state[m_wb] == S_FREE) || (m_state[m_wb] == S_FILL);
    rd_rdy = (m_state[m_rb] == S_READY) || (m_state[m_rb] == S_READ);
    if (rden) begin
      m_wk = '1;
      if (zero) begin
        m_w = '0; m_valid = 1'b1;
      end else if (!rd_rdy) begin
        m_w = '0; m_valid = 1'b0; m_udf = 1'b1;
      end else begin
        m_valid = 1'b1;
        if (int'(rdptr) >= DEPTH) m_w = '0;
        else begin
          m_w = model_row(m_rb, int'(rdptr));
          for (int k = 0; k < LANES; k++) m_wk[k*DW +: DW] = {DW{m_known[m_rb][rdptr][k]}};
        end
        if (m_state[m_rb] == S_READY) m_state[m_rb] = S_READ;
      end
    end else begin
      m_valid = 1'b0;
    end
    if (wren) begin
      if (!wr_rdy) m_ovf = 1'b1;
      else if (int'(wrptr) < DEPTH) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_on(k)) begin
            m_mem[m_wb][wrptr][k]   = wdata[k*DW +: DW];
            m_known[m_wb][wrptr][k] = 1'b1;
          end
        end
        if (m_state[m_wb] == S_FREE) m_state[m_wb] = S_FILL;
      end
    end
    if (commit) begin
      if (wr_rdy) begin
        m_state[m_wb] = S_READY;
        m_wb ^= 1;
      end else m_ovf = 1'b1;
    end
    if (rel && rd_rdy) begin
      m_state[m_rb] = S_FREE;
      m_rb ^= 1;
    end
  endtask

  task automatic compare_all(input string tag);
    bit ewr, erd;
    ewr = (m_state[m_wb] == S_FREE) || (m_state[m_wb] == S_FILL);
    erd = (m_state[m_rb] == S_READY) || (m_state[m_rb] == S_READ);
    check({tag, "/weight"}, weight_o & m_wk, m_w & m_wk);
    check({tag, "/valid"}, W'(valid_o), W'(m_valid));
    check({tag, "/wr_ready"}, W'(wr_ready_o), W'(ewr));
    check({tag, "/rd_ready"}, W'(rd_ready_o), W'(erd));
    check({tag, "/wr_bank"}, W'(wr_bank_o), W'(m_wb));
    check({tag, "/rd_bank"}, W'(rd_bank_o), W'(m_rb));
    check({tag, "/wr_ovf"}, W'(wr_ovf_o), W'(m_ovf));
    check({tag, "/rd_udf"}, W'(rd_udf_o), W'(m_udf));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    wren = 1'b0; commit = 1'b0; rden = 1'b0; zero = 1'b0; rel = 1'b0; wmask = '1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/weight"}, weight_o, '0);
    check({tag, "/valid"}, W'(valid_o), W'(1'b0));
    check({tag, "/wr_ready"}, W'(wr_ready_o), W'(1'b1));
    check({tag, "/rd_ready"}, W'(rd_ready_o), W'(1'b0));
    check({tag, "/wr_bank"}, W'(wr_bank_o), W'(1'b0));
    check({tag, "/rd_bank"}, W'(rd_bank_o), W'(1'b0));
    check({tag, "/wr_ovf"}, W'(wr_ovf_o), W'(1'b0));
    check({tag, "/rd_udf"}, W'(rd_udf_o), W'(1'b0));
  endtask

  initial begin
    logic [W-1:0] exp;
    rst_n = 1'b0;
    idle();
    wrptr = '0; rdptr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill bank 0 rows 0..83 with lane value row+1 and commit it
    for (int r = 0; r < 84; r++) begin
      wren = 1'b1; wrptr = AW'(r); wdata = row_of(8'(r + 1));
      step("fillA");
    end
    idle(); commit = 1'b1;
    step("commitA");
    idle();
    check("A.rd_ready", W'(rd_ready_o), W'(1'b1));

    // Read bank 0 (zero-padded tail) while bank 1 fills
    for (int i = 0; i < DEPTH; i++) begin
      rden = 1'b1; rdptr = AW'(i); zero = (i >= 84);
      wren = 1'b1; wrptr = AW'(i); wdata = rand_row();
      step("readA");
      if (i < 84) check("A.row", weight_o, row_of(8'(i + 1)));
      else check("A.pad", weight_o, '0);
      check("A.valid", W'(valid_o), W'(1'b1));
    end
    idle(); rel = 1'b1; commit = 1'b1;
    step("swap");
    idle();
    check("swap.rd_bank", W'(rd_bank_o), W'(1'b1));
    check("swap.wr_bank", W'(wr_bank_o), W'(1'b0));
    check("swap.ovf", W'(wr_ovf_o), W'(1'b0));
    check("swap.udf", W'(rd_udf_o), W'(1'b0));

    // Both banks ready: overflow write, then underflow read
    for (int r = 0; r < 4; r++) begin
      wren = 1'b1; wrptr = AW'(r); wdata = rand_row();
      step("fillB");
    end
    idle(); commit = 1'b1;
    step("commitB");
    idle();
    check("B.wr_ready", W'(wr_ready_o), W'(1'b0));
    wren = 1'b1; wrptr = 7'd7; wdata = row_of(8'hEE);
    step("ovf_wr");
    idle();
    check("B.ovf", W'(wr_ovf_o), W'(1'b1));
    rden = 1'b1; rdptr = 7'd7;
    step("rd7");
    idle();
    check("B.unchanged", weight_o, model_row(1, 7));
    rel = 1'b1; step("rel1");
    rel = 1'b1; step("rel0");
    idle();
    rden = 1'b1; rdptr = 7'd3;
    step("udf_rd");
    idle();
    check("B.udf_w", weight_o, '0);
    check("B.udf_v", W'(valid_o), W'(1'b0));
    check("B.udf", W'(rd_udf_o), W'(1'b1));

    // Lane-mask write over an existing row
    wren = 1'b1; wrptr = 7'd5; wdata = row_of(8'h11); wmask = '1;
    step("mask_base");
    wmask = '0; wmask[3] = 1'b1; wdata = row_of(8'hAA);
    step("mask_wr");
    idle(); commit = 1'b1;
    step("mask_commit");
    idle(); rden = 1'b1; rdptr = 7'd5;
    step("mask_rd");
    idle();
`ifdef FC_WBUF_LANE_MASK_EN
    exp = row_of(8'h11);
    exp[3*DW +: DW] = 8'hAA;
`else
    exp = row_of(8'hAA);
`endif
    check("C.mask", weight_o, exp);
    rel = 1'b1; step("mask_rel");
    idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      wren   = ($urandom_range(0, 99) < 50);
      wrptr  = AW'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < LANES / 32; i++) wmask[i*32 +: 32] = $urandom;
      wdata  = rand_row();
      commit = ($urandom_range(0, 99) < 8);
      rden   = ($urandom_range(0, 99) < 50);
      rdptr  = AW'($urandom_range(0, DEPTH - 1));
      zero   = ($urandom_range(0, 99) < 15);
      rel    = ($urandom_range(0, 99) < 8);
      step("rnd");
    end

    // Asynchronous reset in the middle of a read
    idle(); rden = 1'b1; rdptr = AW'($urandom_range(0, DEPTH - 1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step("post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
